vec_writeback: RTL

Downstream stage of the vector engine. Consumes its 8-bit result stream (`data_out`/`out_valid`) and packs elements little-endian into 32-bit scratchpad words. It writes those words to SRAM at `base_addr` plus a per-word stride. A small FIFO absorbs write-port stalls from the SRAM arbiter, because the input stream has no backpressure.

---
 rtl/vec_writeback_if.sv | 38 +++
 rtl/vec_writeback.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_writeback_if.sv
// -----------------------------------------------------------------------------
// vec_writeback_if
//   SRAM write port between the vector writeback stage and the scratchpad
//   arbiter. A write transfers on a clock edge where mem_wr_en && mem_wr_ready.
//
//   mem_wr_en     write request (master -> slave)
//   mem_wr_addr   word address (master -> slave)
//   mem_wr_data   packed 32-bit word, lane 0 in bits [7:0] (master -> slave)
//   mem_wr_strb   byte-lane enables (master -> slave)
//   mem_wr_ready  arbiter grant (slave -> master)
// -----------------------------------------------------------------------------
interface vec_writeback_if #(
  parameter int ADDR_WIDTH = 16
) ();

  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [31:0]           mem_wr_data;
  logic [3:0]            mem_wr_strb;
  logic                  mem_wr_ready;

  modport master (
    output mem_wr_en,
    output mem_wr_addr,
    output mem_wr_data,
    output mem_wr_strb,
    input  mem_wr_ready
  );

  modport slave (
    input  mem_wr_en,
    input  mem_wr_addr,
    input  mem_wr_data,
    input  mem_wr_strb,
    output mem_wr_ready
  );

endinterface

// File: rtl/vec_writeback.sv
// -----------------------------------------------------------------------------
// vec_writeback
//   Downstream stage of the vector engine. Collects num_elements 8-bit results
//   from the (non-backpressurable) result stream, packs them little-endian into
//   32-bit words and writes each word to SRAM at base_addr + w*word_stride.
//   Finished words go through a small FIFO so that arbiter stalls do not lose
//   data; if the FIFO is full and cannot drain that cycle, the word is dropped
//   and the sticky overflow flag is raised.
//
//   clk           clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   start         begin a job (only looked at while idle)
//   base_addr     first word address, latched at start
//   word_stride   address increment per word, latched at start
//   num_elements  elements to collect, latched at start
//   data_in       element from the vector engine
//   in_valid      data_in valid this cycle
//   mem           SRAM write port (vec_writeback_if.master)
//   busy          job in progress (COLLECT, DRAIN or DONE)
//   done          one-cycle pulse at the end of every job
//   overflow      sticky: a packed word was dropped; cleared at start
// -----------------------------------------------------------------------------
module vec_writeback #(
  parameter  int DATA_WIDTH   = 8,
  parameter  int MAX_ELEMENTS = 4096,
  parameter  int ADDR_WIDTH   = 16,
  parameter  int FIFO_DEPTH   = 8,
  localparam int CNT_W        = $clog2(MAX_ELEMENTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_stride,
  input  logic [CNT_W-1:0]      num_elements,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  vec_writeback_if.master       mem,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_t;

  // One FIFO entry is a complete write: the address travels with the word so
  // the write side never needs to know how many words were dropped.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
    logic [3:0]            strb;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Job state
  // ---------------------------------------------------------------------------
  state_t                state;
  logic [CNT_W-1:0]      num_cfg;     // latched element count
  logic [ADDR_WIDTH-1:0] stride_cfg;  // latched word stride
  logic [ADDR_WIDTH-1:0] word_addr;   // address of the word being packed
  logic [CNT_W-1:0]      elem_cnt;    // elements accepted so far
  logic [31:0]           lane_reg;    // lanes already filled in current word

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  entry_t                fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        fifo_cnt;

  logic                  fifo_empty;
  logic                  fifo_full;
  entry_t                head;

  // ---------------------------------------------------------------------------
  // Element acceptance and word assembly
  // ---------------------------------------------------------------------------
  logic       accept;
  logic       last_elem;
  logic [1:0] lane;
  logic       push_req;
  logic       push;
  logic       pop;
  logic       drop;
  logic [31:0] push_data;
  logic [3:0]  push_strb;
  entry_t      push_entry;

  // Counter never exceeds num_cfg, so "accepted < num" is simply "!=".
  assign accept    = (state == S_COLLECT) && in_valid && (elem_cnt != num_cfg);
  assign last_elem = (elem_cnt + CNT_W'(1)) == num_cfg;
  assign lane      = elem_cnt[1:0];
  assign push_req  = accept && ((lane == 2'd3) || last_elem);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    push_data = lane_reg;
    push_strb = 4'b0000;
    unique case (lane)
      2'd0: begin
        push_data[0*DATA_WIDTH +: DATA_WIDTH] = data_in;
        push_strb                             = 4'b0001;
      end
      2'd1: begin
        push_data[1*DATA_WIDTH +: DATA_WIDTH] = data_in;
        push_strb                             = 4'b0011;
      end
      2'd2: begin
        push_data[2*DATA_WIDTH +: DATA_WIDTH] = data_in;
        push_strb                             = 4'b0111;
      end
      2'd3: begin
        push_data[3*DATA_WIDTH +: DATA_WIDTH] = data_in;
        push_strb                             = 4'b1111;
      end
      default: begin
        push_data = lane_reg;
        push_strb = 4'b0000;
      end
    endcase
  end

  assign push_entry = '{addr: word_addr, data: push_data, strb: push_strb};

  // ---------------------------------------------------------------------------
  // FIFO control. A pop on the same edge frees a slot, so a push into a full
  // FIFO is only lost when the write port is stalled at that moment.
  // ---------------------------------------------------------------------------
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && mem.mem_wr_ready;
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  // NOTE: the entry storage has no reset; an entry is only visible on the port
  // once fifo_cnt says it was written, and the port is forced to 0 when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write port: straight from the FIFO head register, so it holds steady for
  // as long as the arbiter withholds ready.
  // ---------------------------------------------------------------------------
  assign head            = fifo_mem[rd_ptr];
  assign mem.mem_wr_en   = !fifo_empty;
  assign mem.mem_wr_addr = fifo_empty ? '0 : head.addr;
  assign mem.mem_wr_data = fifo_empty ? '0 : head.data;
  assign mem.mem_wr_strb = fifo_empty ? '0 : head.strb;

  // ---------------------------------------------------------------------------
  // Job FSM with registered status outputs.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge value of every other one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      num_cfg    <= '0;
      stride_cfg <= '0;
      word_addr  <= '0;
      elem_cnt   <= '0;
      lane_reg   <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_COLLECT;
            busy       <= 1'b1;
            num_cfg    <= num_elements;
            stride_cfg <= word_stride;
            word_addr  <= base_addr;
            elem_cnt   <= '0;
            lane_reg   <= '0;
            overflow   <= 1'b0;
          end
        end

        S_COLLECT: begin
          if (accept) begin
            elem_cnt <= elem_cnt + CNT_W'(1);
            if (push_req) begin
              // Advance the address even when the word was dropped, so the
              // words that do get through land at their proper addresses.
              lane_reg  <= '0;
              word_addr <= word_addr + stride_cfg;
            end else begin
              lane_reg <= push_data;
            end
          end
          // Checked on the registered count: a job of zero elements leaves
          // on its first COLLECT cycle.
          if (elem_cnt == num_cfg) begin
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (fifo_empty) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
